// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO read/write pointer controller with occupancy, status and sticky error flags
module fifo_ctrl #(
    parameter int W        = 2,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic         clear_err,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic         empty,
    output logic         full,
    output logic [W:0]   count,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] DEPTH  = {1'b1, {W{1'b0}}};
    localparam logic [W:0] AF_THR = AF_LEVEL[W:0];
    localparam logic [W:0] AE_THR = AE_LEVEL[W:0];

    logic       do_wr;
    logic       do_rd;
    logic [W:0] count_next;

    always_comb begin
        // A pop on a full FIFO frees the slot the simultaneous push lands in.
        do_wr      = wr & (~full | rd);
        do_rd      = rd & ~empty;
        wr_en      = do_wr;
        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + (W+1)'(1);
            2'b01:   count_next = count - (W+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_addr       <= '0;
            r_addr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= (AF_LEVEL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (do_wr) w_addr <= w_addr + W'(1);
            if (do_rd) r_addr <= r_addr + W'(1);
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH);
            almost_full  <= (count_next >= AF_THR);
            almost_empty <= (count_next <= AE_THR);
            // A new error event in the same cycle as clear_err keeps the flag set.
            overflow     <= (overflow & ~clear_err) | (wr & full & ~rd);
            underflow    <= (underflow & ~clear_err) | (rd & empty);
        end
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Read/write pointer controller that sits directly upstream of the team's register-file storage array; together they form a synchronous FIFO.
- Converts push/pop requests into `wr_en`, `w_addr` and `r_addr` for the array.
- Tracks occupancy, full/empty and almost-full/almost-empty status, and sticky overflow/underflow error flags.
- Read data comes from the array combinationally at `r_addr` (first-word-fall-through); this block carries no data.

Parameters:
- W, 2, address bits; FIFO depth = 2**W (must match the storage array's W).
- AF_LEVEL, 3, almost_full asserts when count >= AF_LEVEL (1..2**W).
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..2**W-1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  push request; data presented to the array's w_data this cycle.
- rd  input  1  pop request; consumes the word currently at r_addr.
- clear_err  input  1  clears the overflow/underflow sticky flags.
- wr_en  output  1  write strobe to the storage array (combinational).
- w_addr  output  W  write pointer to the storage array (registered).
- r_addr  output  W  read pointer to the storage array (registered).
- empty  output  1  FIFO holds 0 words (registered).
- full  output  1  FIFO holds 2**W words (registered).
- count  output  W+1  occupancy, 0..2**W (registered).
- almost_full  output  1  count >= AF_LEVEL (registered).
- almost_empty  output  1  count <= AE_LEVEL (registered).
- overflow  output  1  sticky: a push was dropped (registered).
- underflow  output  1  sticky: a pop was ignored (registered).

Behaviour:
- Reset (clk edge with reset=1): w_addr=0, r_addr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), overflow=0, underflow=0. Reset overrides all requests in that cycle. A reset mid-stream discards contents; array contents are not cleared.
- Effective operations, from the registered flags of the current cycle:
  - do_wr = wr & (~full | rd).
  - do_rd = rd & ~empty.
- wr_en = do_wr; combinational, with no dependency on clear_err.
- Pointers increment modulo 2**W, wrapping 2**W-1 -> 0. Each updates on the edge after its effective operation; latency 1 cycle.
- Per-case updates:
  - {do_wr, do_rd} = 10: w_addr+1, count+1.
  - 01: r_addr+1, count-1.
  - 11: both pointers +1, count unchanged.
  - 00: hold.
- Next-state flags are computed from the next count:
  - empty = (count_next == 0).
  - full = (count_next == 2**W).
  - almost_full and almost_empty use the same thresholds.
  - All flags update on the same edge as count.
- Full with rd&wr: both proceed. The write lands at w_addr == r_addr on the edge, after the current word was read combinationally. full stays 1 and overflow is not set.
- Empty with rd&wr: write proceeds, rd is ignored, underflow is set. Next cycle: count=1, empty=0.
- overflow is set on the edge when wr & full & ~rd.
- underflow is set on the edge when rd & empty.
- Both error flags hold until a cycle with clear_err=1. If clear_err and a new error event occur in the same cycle, the event wins and the flag stays 1.
- Dropped or ignored requests never move pointers or count.
- Invariants: count == (w_addr - r_addr) mod 2**W, except count == 2**W when full. full and empty are never both 1.

Test Plan:
1. W=2: reset, then 4 pushes -> w_addr 1,2,3,0; count 1..4; almost_full rises on the 3rd push; full=1 after the 4th; r_addr=0.
2. From full, wr=1 for one cycle -> wr_en=0; overflow=1 next cycle; w_addr=0 and count=4 unchanged. Then clear_err=1 -> overflow=0.
3. From full, rd=1 and wr=1 for 3 cycles -> wr_en=1 each cycle; both pointers advance to 3; count stays 4; full stays 1; no error flags.
4. From empty, rd=1 alone -> underflow=1, r_addr stays 0, empty stays 1. Then rd=1 and wr=1 -> count=1, empty=0, w_addr=1, r_addr=0.
5. Push 2, pop 2, repeated 6 times -> pointers wrap 3->0 without glitching empty/full; count oscillates 0..2; almost_empty=1 whenever count<=1.
6. Assert reset while count=3 and wr=1 -> next cycle: all pointers 0, count=0, empty=1, flags cleared, wr request ignored.
